key_sw_reader: RTL and testbench
================================

KEY_SW_READER -- requirements
Module: key_sw_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable cycles required before a debounced input changes (20 ms at 50 MHz); legal range 2 to 2^24.
REQ-002 CLOCK_50  input  1  sole clock, rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 KEY  input  2  raw pushbuttons, active-low; KEY[1] is the capture key, KEY[0] is the clear key.
REQ-005 SW  input  10  raw slide switches.
REQ-006 data  output  10  captured switch word.
REQ-007 valid  output  1  data holds an unconsumed capture.
REQ-008 ready  input  1  consumer accepts data in a cycle when valid&&ready.
REQ-009 overflow  output  1  sticky flag: a capture was dropped.
REQ-010 press_count  output  8  count of accepted captures, wraps.

Function
REQ-011 Each KEY and SW bit shall pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized bit shall have a debounced "stable" value and its own counter; the counter clears when sample==stable, otherwise increments; stable takes the sample when the counter reaches DEBOUNCE_CYCLES-1, and the counter then clears.
REQ-013 A press event shall be a one-cycle pulse when a debounced KEY bit goes 1->0; release events shall be ignored.
REQ-014 The FSM shall have states IDLE (valid=0) and HOLD (valid=1).
REQ-015 IDLE + KEY[1] press -> HOLD; data <= debounced SW in that cycle; press_count += 1.
REQ-016 HOLD + valid&&ready without a KEY[1] press -> IDLE.
REQ-017 HOLD + KEY[1] press + ready in the same cycle -> stay in HOLD, data reloads, press_count += 1.
REQ-018 HOLD + KEY[1] press + !ready -> capture dropped, data unchanged, overflow <= 1, press_count unchanged.
REQ-019 A KEY[0] press shall force IDLE and clear overflow, in any state.
REQ-020 A KEY[0] press in the same cycle as a KEY[1] press shall win: no capture and no count.
REQ-021 A KEY[0] press in the same cycle as a valid&&ready handshake shall still complete that handshake; the consumer sees the handshake.
REQ-022 data shall not change while valid=1, except under REQ-017.
REQ-023 press_count shall wrap from 255 to 0 with no flag.
REQ-024 Latency from a raw KEY[1] edge to valid shall be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-025 RESET shall asynchronously set state=IDLE, valid=0, data=0, overflow=0, press_count=0, all debounce counters=0.
REQ-026 RESET shall set debounced KEY stable values to 1 (released), debounced SW stable values to 0, and synchronizer flops to the same values.
REQ-027 Deassertion of RESET while a key is held shall not produce a press event until the key is released and pressed again.

Configuration
REQ-028 Macro SW_DEBOUNCE_EN defined: SW bits are debounced per REQ-012.
REQ-029 Macro SW_DEBOUNCE_EN undefined: SW bits are only synchronized, and data captures the synchronized SW directly; KEY debouncing is always present.

Structure
REQ-030 Package key_sw_pkg shall hold the FSM state enum (IDLE, HOLD), the key index constants KEY_CLR=0 and KEY_CAP=1, and SW_W=10.
REQ-031 Sub-module debounce, instantiated per bit, shall contain the synchronizer, the counter, the stable register, and a parameterized reset value.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 SW=0x2A5, KEY[1] held low for 10 cycles, ready=0 -> valid=1 and data=0x2A5 at cycle 7 after the edge; press_count=1.
REQ-033 KEY[1] bounces low/high every 2 cycles for 12 cycles, then goes high -> no press event and valid stays 0.
REQ-034 valid=1, ready=0, second KEY[1] press with SW=0x011 -> data unchanged, overflow=1; then KEY[0] press -> valid=0, overflow=0.
REQ-035 valid=1, ready=1 in the same cycle as a KEY[1] press with SW=0x3FF -> valid stays 1, data=0x3FF, press_count increments.
REQ-036 256 accepted captures from reset -> press_count=0; RESET asserted mid-debounce -> all outputs at reset values immediately, with no clock required.

Source files
------------

// File: rtl/key_sw_pkg.sv
// Shared types and constants for the key/switch capture block.
package key_sw_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int KEY_W   = 2;
  localparam int KEY_CLR = 0;
  localparam int KEY_CAP = 1;
  localparam int SW_W    = 10;

  // Counter width needed to reach cycles-1 (cycles >= 2).
  function automatic int cnt_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_sw_reader_debounce.sv
// Per-bit 2-flop synchronizer plus counter-based debouncer.
// FILTER=0 skips the counter and passes the synchronized bit straight to q.
module debounce
  import key_sw_pkg::*;
#(
  parameter int unsigned CYCLES  = 1000000,
  parameter bit          RST_VAL = 1'b0,
  parameter bit          FILTER  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic q
);

  logic s1, s2;

  // Two-flop synchronizer; resets to the idle level of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign sync = s2;

  generate
    if (FILTER) begin : g_filt
      localparam int CNT_W = cnt_width(CYCLES);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             stable;

      // Count consecutive disagreeing samples; adopt the sample once it has
      // disagreed for CYCLES cycles in a row.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt    <= '0;
          stable <= RST_VAL;
        end else if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign q = stable;
    end else begin : g_pass
      assign q = s2;
    end
  endgenerate

endmodule

// File: rtl/key_sw_reader.sv
// Key/switch reader: debounced KEY[1] captures the switch word into a
// valid/ready holding register, KEY[0] clears. Define SW_DEBOUNCE_EN to
// debounce the switches as well; otherwise they are only synchronized.
module key_sw_reader
  import key_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [KEY_W-1:0] KEY,
  input  logic [SW_W-1:0]  SW,
  output logic [SW_W-1:0]  data,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  output logic [7:0]       press_count
);

`ifdef SW_DEBOUNCE_EN
  localparam bit SW_FILT = 1'b1;
`else
  localparam bit SW_FILT = 1'b0;
`endif

  logic [KEY_W-1:0] key_sync, key_db, key_prev, key_fall, armed;
  logic [SW_W-1:0]  sw_db, sw_sync_unused;
  logic [1:0]       flush;

  generate
    for (genvar i = 0; i < KEY_W; i++) begin : g_key
      debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1), .FILTER(1'b1)) u_db (
        .clk (CLOCK_50),
        .rst (RESET),
        .din (KEY[i]),
        .sync(key_sync[i]),
        .q   (key_db[i])
      );
    end
    for (genvar i = 0; i < SW_W; i++) begin : g_sw
      debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0), .FILTER(SW_FILT)) u_db (
        .clk (CLOCK_50),
        .rst (RESET),
        .din (SW[i]),
        .sync(sw_sync_unused[i]),
        .q   (sw_db[i])
      );
    end
  endgenerate

  // A key is armed only after its real (post-reset) synchronized level has
  // been seen released, so a key held through reset never yields a press.
  // flush marks when the synchronizer holds real samples instead of reset values.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      flush    <= '0;
      armed    <= '0;
      key_prev <= '1;
    end else begin
      flush    <= {flush[0], 1'b1};
      armed    <= armed | ({KEY_W{flush[1]}} & key_sync);
      key_prev <= key_db;
    end
  end

  // One-cycle press pulse on a debounced 1->0 edge; releases are ignored.
  assign key_fall = armed & key_prev & ~key_db;

  logic            cap, clr;
  state_t          state, state_nxt;
  logic [SW_W-1:0] data_nxt;
  logic            ovf_nxt;
  logic [7:0]      cnt_nxt;

  assign cap   = key_fall[KEY_CAP];
  assign clr   = key_fall[KEY_CLR];
  assign valid = (state == HOLD);

  // State and capture registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      data        <= '0;
      overflow    <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      data        <= data_nxt;
      overflow    <= ovf_nxt;
      press_count <= cnt_nxt;
    end
  end

  // Next-state logic. Clear beats capture; a handshake in the clear cycle
  // still completes because valid&&ready is visible to the consumer then.
  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    ovf_nxt   = overflow;
    cnt_nxt   = press_count;
    if (clr) begin
      state_nxt = IDLE;
      ovf_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cap) begin
            state_nxt = HOLD;
            data_nxt  = sw_db;
            cnt_nxt   = press_count + 8'd1;
          end
        end
        HOLD: begin
          if (cap) begin
            if (ready) begin
              data_nxt = sw_db;
              cnt_nxt  = press_count + 8'd1;
            end else begin
              ovf_nxt = 1'b1;
            end
          end else if (ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sw_reader.sv
// Directed bench for key_sw_reader with DEBOUNCE_CYCLES=4.
module tb_key_sw_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] data;
  logic       valid, ready, overflow;
  logic [7:0] press_count;

  int n_chk = 0;
  int n_err = 0;

  key_sw_reader #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .KEY        (key),
    .SW         (sw),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold a key low long enough to debounce, then release and let it settle.
  task automatic press(input int k);
    key[k] = 1'b0;
    tick(8);
    key[k] = 1'b1;
    tick(8);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"},  32'(data), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
    chk({tag, "_cnt"},   32'(press_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; key = 2'b11; sw = '0; ready = 1'b0;
    tick(3);
    chk_reset("rst");
    rst = 1'b0;
    tick(5);

    // Single capture: valid appears 2 + 4 + 1 = 7 cycles after the edge.
    sw = 10'h2A5;
    key[1] = 1'b0;
    tick(6);
    chk("lat_before", 32'(valid), 32'd0);
    tick(1);
    chk("lat_valid", 32'(valid), 32'd1);
    chk("lat_data",  32'(data), 32'h2A5);
    chk("lat_cnt",   32'(press_count), 32'd1);
    tick(3);
    key[1] = 1'b1;
    tick(8);
    chk("rel_valid", 32'(valid), 32'd1);
    chk("rel_cnt",   32'(press_count), 32'd1);

    // Second capture with no ready is dropped; clear resets valid/overflow.
    sw = 10'h011;
    press(1);
    chk("ovf_data",  32'(data), 32'h2A5);
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_cnt",   32'(press_count), 32'd1);
    chk("ovf_valid", 32'(valid), 32'd1);
    press(0);
    chk("clr_valid", 32'(valid), 32'd0);
    chk("clr_ovf",   32'(overflow), 32'd0);

    // Bouncing key never stays low long enough to count.
    for (int i = 0; i < 3; i++) begin
      key[1] = 1'b0; tick(2);
      key[1] = 1'b1; tick(2);
    end
    tick(10);
    chk("bounce_valid", 32'(valid), 32'd0);
    chk("bounce_cnt",   32'(press_count), 32'd1);

    // Capture, then reload with ready high in the press cycle.
    sw = 10'h155;
    press(1);
    chk("cap2_data", 32'(data), 32'h155);
    chk("cap2_cnt",  32'(press_count), 32'd2);
    sw = 10'h3FF;
    key[1] = 1'b0;
    tick(6);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("reload_valid", 32'(valid), 32'd1);
    chk("reload_data",  32'(data), 32'h3FF);
    chk("reload_cnt",   32'(press_count), 32'd3);
    key[1] = 1'b1;
    tick(8);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("hs_valid", 32'(valid), 32'd0);

    // Clear and capture pressed together: clear wins.
    key = 2'b00;
    tick(8);
    key = 2'b11;
    tick(8);
    chk("both_valid", 32'(valid), 32'd0);
    chk("both_cnt",   32'(press_count), 32'd3);

    // 256 accepted captures from reset wrap the counter to zero.
    rst = 1'b1; tick(1); rst = 1'b0; tick(5);
    ready = 1'b1;
    for (int i = 0; i < 255; i++) press(1);
    chk("wrap_255", 32'(press_count), 32'd255);
    press(1);
    chk("wrap_0", 32'(press_count), 32'd0);
    ready = 1'b0;

    // Build up state, then assert reset mid-debounce away from a clock edge.
    sw = 10'h0F0;
    press(1);
    press(1);
    chk("pre_valid", 32'(valid), 32'd1);
    chk("pre_ovf",   32'(overflow), 32'd1);
    key[1] = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1 chk_reset("async");
    tick(2);
    rst = 1'b0;

    // Key held through reset must not produce a press.
    tick(15);
    chk("held_valid", 32'(valid), 32'd0);
    chk("held_cnt",   32'(press_count), 32'd0);
    key[1] = 1'b1;
    tick(10);
    press(1);
    chk("rearm_valid", 32'(valid), 32'd1);
    chk("rearm_cnt",   32'(press_count), 32'd1);
    chk("rearm_data",  32'(data), 32'h0F0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
